instr_fetch_pipe: RTL and testbench

INSTR_FETCH_PIPE -- requirements
Module: instr_fetch_pipe

---
 rtl/instr_fetch_pipe_pkg.sv | 33 +++
 rtl/instr_fetch_pipe_if.sv | 46 ++++
 rtl/fetch_addr_fifo.sv | 84 ++++++++
 rtl/instr_fetch_pipe.sv | 113 +++++++++++
 tb/tb_instr_fetch_pipe.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pipe_pkg.sv
// instr_fetch_pipe_pkg
// Shared types for the instruction fetch pipe:
//   gpreg_t    - machine word used for addresses and instruction data
//   mem_req_t  - memory request {a, we, be, d}
//   fetched_t  - fetched instruction {raw, pc}
//   MAX_INFLIGHT_MIN/MAX - legal range of outstanding memory requests
//   cnt_width() - bits needed to hold a count 0..n
package instr_fetch_pipe_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] gpreg_t;

  typedef struct packed {
    gpreg_t              a;
    logic                we;
    logic [XLEN/8-1:0]   be;
    gpreg_t              d;
  } mem_req_t;

  typedef struct packed {
    gpreg_t raw;
    gpreg_t pc;
  } fetched_t;

  localparam int MAX_INFLIGHT_MIN = 1;
  localparam int MAX_INFLIGHT_MAX = 16;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/instr_fetch_pipe_if.sv
// instr_fetch_pipe_if
// Bundles the four decoupled channels of the fetch pipe plus the flush strobe.
//   pc       : next fetch address   (pc_valid / pc_ready / pc_data)
//   fetched  : instruction + address (fetched_valid / fetched_ready / fetched_data)
//   mem_req  : read request to memory (mem_req_valid / mem_req_ready / mem_req_data)
//   mem_resp : read data from memory, in request order
//   flush    : discard everything queued or in flight this cycle
// Modports: slave = fetch pipe view, master = surrounding environment view.
interface instr_fetch_pipe_if;
  import instr_fetch_pipe_pkg::*;

  logic     pc_valid;
  logic     pc_ready;
  gpreg_t   pc_data;

  logic     fetched_valid;
  logic     fetched_ready;
  fetched_t fetched_data;

  logic     flush;

  logic     mem_req_valid;
  logic     mem_req_ready;
  mem_req_t mem_req_data;

  logic     mem_resp_valid;
  logic     mem_resp_ready;
  gpreg_t   mem_resp_data;

  modport slave (
    input  pc_valid, pc_data, output pc_ready,
    output fetched_valid, fetched_data, input fetched_ready,
    input  flush,
    output mem_req_valid, mem_req_data, input mem_req_ready,
    input  mem_resp_valid, mem_resp_data, output mem_resp_ready
  );

  modport master (
    output pc_valid, pc_data, input pc_ready,
    input  fetched_valid, fetched_data, output fetched_ready,
    output flush,
    input  mem_req_valid, mem_req_data, output mem_req_ready,
    output mem_resp_valid, mem_resp_data, input mem_resp_ready
  );

endinterface

// File: rtl/fetch_addr_fifo.sv
// fetch_addr_fifo
// Small circular FIFO holding the addresses of live fetch requests.
// Head is read combinationally so it can accompany the response in the same cycle.
// Parameters: DEPTH (entries), T (entry type)
// Ports:
//   clk, rst            clock, asynchronous active-high reset of pointers/count
//   push_i, data_i      write data_i at the tail (ignored when full or clearing)
//   pop_i               drop the head (ignored when empty or clearing)
//   clear_i             empty the FIFO; wins over push/pop
//   head_o              oldest entry
//   count_o, full_o, empty_o  occupancy status
module fetch_addr_fifo
  import instr_fetch_pipe_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic                        clear_i,
  input  T                            data_i,
  output T                            head_o,
  output logic [cnt_width(DEPTH)-1:0] count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_pipe.sv
// instr_fetch_pipe
// Issues fetch addresses to memory, tracks up to MAX_INFLIGHT outstanding reads
// and pairs each in-order response with its address. A flush turns every live
// request into a "drop" whose response is silently absorbed later.
// Parameter: MAX_INFLIGHT (1..16) maximum outstanding memory requests.
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   instr_fetch_pipe_if.slave (pc, fetched, flush, mem_req, mem_resp)
//   perf_issued, perf_dropped   only when IFETCH_PERF_EN is defined:
//         free-running counts of issued requests and discarded responses
module instr_fetch_pipe
  import instr_fetch_pipe_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_fetch_pipe_if.slave     bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_dropped
`endif
);

  localparam int CW = cnt_width(MAX_INFLIGHT);
  localparam int OW = CW + 1;

  if (MAX_INFLIGHT < MAX_INFLIGHT_MIN || MAX_INFLIGHT > MAX_INFLIGHT_MAX) begin : g_bad_cfg
    $error("instr_fetch_pipe: MAX_INFLIGHT out of range");
  end

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  gpreg_t        fifo_head;
  logic [CW-1:0] drop_q, drop_d;
  logic [OW-1:0] outstanding, drop_sum;
  logic          issue_ok, drop_mode, push, pop, resp_fire;

  // Uses registered occupancy only, so a pop in the same cycle never frees a slot early.
  assign outstanding = OW'(fifo_count) + OW'(drop_q);
  assign issue_ok    = !rst && !bus.flush && !fifo_full && (outstanding < OW'(MAX_INFLIGHT));

  assign bus.mem_req_valid = bus.pc_valid && issue_ok;
  assign bus.pc_ready      = bus.mem_req_ready && issue_ok;
  assign bus.mem_req_data  = '{a: bus.pc_data, we: 1'b0, be: '0, d: '0};

  // While drops are pending every response belongs to a flushed request.
  assign drop_mode          = (drop_q != '0);
  assign bus.fetched_valid  = !rst && !bus.flush && !drop_mode && !fifo_empty && bus.mem_resp_valid;
  assign bus.mem_resp_ready = !rst && (bus.flush || drop_mode || bus.fetched_ready);
  assign bus.fetched_data   = '{raw: bus.mem_resp_data, pc: fifo_head};

  assign push      = bus.mem_req_valid && bus.mem_req_ready;
  assign pop       = bus.fetched_valid && bus.fetched_ready;
  assign resp_fire = bus.mem_resp_valid && bus.mem_resp_ready;

  fetch_addr_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .T     (gpreg_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (bus.flush),
    .data_i  (bus.pc_data),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // On flush, every live request becomes a drop; a response consumed in the
  // flush cycle itself is already accounted for.
  always_comb begin
    drop_sum = OW'(drop_q) + OW'(fifo_count);
    drop_d   = drop_q;
    if (bus.flush) begin
      if (resp_fire && drop_sum != '0) drop_sum = drop_sum - 1'b1;
      drop_d = CW'(drop_sum);
    end else if (drop_mode && resp_fire) begin
      drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_issued_q, perf_dropped_q;
  logic        discard;

  assign discard = resp_fire && (bus.flush || drop_mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued_q  <= '0;
      perf_dropped_q <= '0;
    end else begin
      if (push)    perf_issued_q  <= perf_issued_q + 32'd1;
      if (discard) perf_dropped_q <= perf_dropped_q + 32'd1;
    end
  end

  assign perf_issued  = perf_issued_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_instr_fetch_pipe.sv
// tb_instr_fetch_pipe
// Table-driven directed sequences, hand-written backpressure and reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_instr_fetch_pipe;
  import instr_fetch_pipe_pkg::*;

  localparam int MAXI = 4;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_pipe_if ifc();

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_issued, perf_dropped;
`endif

  instr_fetch_pipe #(.MAX_INFLIGHT(MAXI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_issued  (perf_issued),
    .perf_dropped (perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // in_f = {pc_valid, mem_req_ready, mem_resp_valid, fetched_ready, flush}
  // exp_f = {mem_req_valid, pc_ready, fetched_valid, mem_resp_ready}
  typedef struct {
    logic [4:0] in_f;
    gpreg_t     pcd;
    gpreg_t     rd;
    logic [3:0] exp_f;
    gpreg_t     fpc;
  } vec_t;

  vec_t vecs[$];

  // Reference memory contents: data returned for a given fetch address.
  function automatic gpreg_t mem_data(input gpreg_t a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  function automatic vec_t mk(input logic [4:0] in_f, input gpreg_t pcd, input gpreg_t rd,
                              input logic [3:0] exp_f, input gpreg_t fpc);
    vec_t v;
    v.in_f = in_f; v.pcd = pcd; v.rd = rd; v.exp_f = exp_f; v.fpc = fpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] f, input gpreg_t pcd, input gpreg_t rd);
    ifc.pc_valid       = f[4];
    ifc.mem_req_ready  = f[3];
    ifc.mem_resp_valid = f[2];
    ifc.fetched_ready  = f[1];
    ifc.flush          = f[0];
    ifc.pc_data        = pcd;
    ifc.mem_resp_data  = rd;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e, input gpreg_t fpc, input gpreg_t raw);
    chk({tag, ".mem_req_valid"}, 32'(ifc.mem_req_valid), 32'(e[3]));
    chk({tag, ".pc_ready"},      32'(ifc.pc_ready),      32'(e[2]));
    chk({tag, ".fetched_valid"}, 32'(ifc.fetched_valid), 32'(e[1]));
    chk({tag, ".mem_resp_ready"},32'(ifc.mem_resp_ready),32'(e[0]));
    if (e[1]) begin
      chk({tag, ".fetched_pc"},  ifc.fetched_data.pc,  fpc);
      chk({tag, ".fetched_raw"}, ifc.fetched_data.raw, raw);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(5'b0, '0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Reference model state
  gpreg_t live_q[$];   // addresses awaiting a delivered response
  gpreg_t mem_q[$];    // every request the memory still owes a response for
  int     drop;
  int     model_issued, model_dropped;

  initial begin
    logic [4:0] f;
    logic       e_mrv, e_pcr, e_fv, e_rr, resp_fire;
    int         outst;
    gpreg_t     pcd, rd;

    // ---------------- reset state, checked before any clock edge
    rst = 1'b1;
    drive(5'b11110, 32'h0000_0100, 32'h1234_5678);
    #3;
    check_outs("reset", 4'b0000, '0, '0);
`ifdef IFETCH_PERF_EN
    chk("reset.perf_issued", perf_issued, 32'd0);
    chk("reset.perf_dropped", perf_dropped, 32'd0);
`endif
    drive(5'b0, '0, '0);
    step();
    rst = 1'b0;

    // ---------------- directed table
    // back-to-back issue and in-order return
    vecs.push_back(mk(5'b11010, 32'h100, 32'h0,         4'b1101, 32'h0));
    vecs.push_back(mk(5'b11010, 32'h104, 32'h0,         4'b1101, 32'h0));
    vecs.push_back(mk(5'b11010, 32'h108, 32'h0,         4'b1101, 32'h0));
    vecs.push_back(mk(5'b11010, 32'h10C, 32'h0,         4'b1101, 32'h0));
    vecs.push_back(mk(5'b11010, 32'h110, 32'h0,         4'b0001, 32'h0));
    vecs.push_back(mk(5'b11110, 32'h110, 32'hD000_0000, 4'b0011, 32'h100));
    vecs.push_back(mk(5'b01110, 32'h0,   32'hD000_0001, 4'b0111, 32'h104));
    vecs.push_back(mk(5'b01110, 32'h0,   32'hD000_0002, 4'b0111, 32'h108));
    vecs.push_back(mk(5'b01110, 32'h0,   32'hD000_0003, 4'b0111, 32'h10C));
    // flush with three in flight
    vecs.push_back(mk(5'b11010, 32'h300, 32'h0,         4'b1101, 32'h0));
    vecs.push_back(mk(5'b11010, 32'h304, 32'h0,         4'b1101, 32'h0));
    vecs.push_back(mk(5'b11010, 32'h308, 32'h0,         4'b1101, 32'h0));
    vecs.push_back(mk(5'b11011, 32'h30C, 32'h0,         4'b0001, 32'h0));
    vecs.push_back(mk(5'b11110, 32'h200, 32'hBAD0_0000, 4'b1101, 32'h0));
    vecs.push_back(mk(5'b01100, 32'h0,   32'hBAD0_0001, 4'b0101, 32'h0));
    vecs.push_back(mk(5'b01100, 32'h0,   32'hBAD0_0002, 4'b0101, 32'h0));
    vecs.push_back(mk(5'b01110, 32'h0,   32'h2222_2222, 4'b0111, 32'h200));
    // flush coinciding with a response
    vecs.push_back(mk(5'b11010, 32'h400, 32'h0,         4'b1101, 32'h0));
    vecs.push_back(mk(5'b11010, 32'h404, 32'h0,         4'b1101, 32'h0));
    vecs.push_back(mk(5'b01111, 32'h0,   32'hBAD0_0003, 4'b0001, 32'h0));
    vecs.push_back(mk(5'b01010, 32'h0,   32'h0,         4'b0101, 32'h0));
    vecs.push_back(mk(5'b01110, 32'h0,   32'hBAD0_0004, 4'b0101, 32'h0));
    vecs.push_back(mk(5'b01000, 32'h0,   32'h0,         4'b0100, 32'h0));

    foreach (vecs[i]) begin
      drive(vecs[i].in_f, vecs[i].pcd, vecs[i].rd);
      #4;
      check_outs($sformatf("vec%0d", i), vecs[i].exp_f, vecs[i].fpc, vecs[i].rd);
      $display("vec %0d in=%b pc=%h rd=%h -> mrv=%b pcr=%b fv=%b rr=%b fpc=%h", i,
               vecs[i].in_f, vecs[i].pcd, vecs[i].rd, ifc.mem_req_valid, ifc.pc_ready,
               ifc.fetched_valid, ifc.mem_resp_ready, ifc.fetched_data.pc);
      step();
    end

    // ---------------- backpressure: response held while fetched_ready is low
    do_reset();
    drive(5'b11010, 32'h500, '0);
    step();
    for (int c = 0; c < 5; c++) begin
      drive(5'b00100, '0, 32'hAAAA_5555);
      #4;
      check_outs($sformatf("bp%0d", c), 4'b0010, 32'h500, 32'hAAAA_5555);
      step();
    end
    drive(5'b00110, '0, 32'hAAAA_5555);
    #4;
    check_outs("bp_release", 4'b0011, 32'h500, 32'hAAAA_5555);
    step();
    drive(5'b11010, 32'h504, '0);
    step();
    drive(5'b01110, '0, 32'h0504_0504);
    #4;
    check_outs("bp_next", 4'b0111, 32'h504, 32'h0504_0504);
    $display("backpressure sequence done");
    step();

    // ---------------- mid-operation reset with two outstanding
    do_reset();
    drive(5'b11010, 32'h600, '0);
    step();
    drive(5'b11010, 32'h604, '0);
    step();
    drive(5'b11110, 32'h608, 32'h6666_0000);
    #1;
    rst = 1'b1;
    #1;
    check_outs("midrst", 4'b0000, '0, '0);
`ifdef IFETCH_PERF_EN
    chk("midrst.perf_issued", perf_issued, 32'd0);
`endif
    drive(5'b0, '0, '0);
    step();
    rst = 1'b0;
    // Four issues must all be accepted if the counts really cleared.
    for (int k = 0; k < 4; k++) begin
      drive(5'b11010, 32'h700 + 32'(4 * k), '0);
      #4;
      check_outs($sformatf("post_rst_issue%0d", k), 4'b1101, '0, '0);
      step();
    end
    drive(5'b11010, 32'h710, '0);
    #4;
    check_outs("post_rst_full", 4'b0001, '0, '0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(5'b00110, '0, 32'h7000 + 32'(k));
      #4;
      check_outs($sformatf("post_rst_resp%0d", k), 4'b0011, 32'h700 + 32'(4 * k), 32'h7000 + 32'(k));
      step();
    end
    $display("mid-reset sequence done");

    // ---------------- randomized traffic against reference model
    do_reset();
    live_q.delete();
    mem_q.delete();
    drop = 0;
    model_issued = 0;
    model_dropped = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      f[4] = ($urandom_range(3) != 0);
      f[3] = ($urandom_range(3) != 0);
      f[2] = (mem_q.size() > 0) && ($urandom_range(1) == 1);
      f[1] = ($urandom_range(2) != 0);
      f[0] = ($urandom_range(24) == 0);
      pcd  = $urandom() & 32'hFFFF_FFFC;
      rd   = f[2] ? mem_data(mem_q[0]) : 32'h0;
      drive(f, pcd, rd);
      #4;
      outst = live_q.size() + drop;
      e_mrv = f[4] && !f[0] && (outst < MAXI);
      e_pcr = f[3] && !f[0] && (outst < MAXI);
      e_fv  = !f[0] && (drop == 0) && f[2] && (live_q.size() > 0);
      e_rr  = (f[0] || drop > 0) ? 1'b1 : f[1];
      check_outs($sformatf("rnd%0d", cyc), {e_mrv, e_pcr, e_fv, e_rr},
                 (live_q.size() > 0) ? live_q[0] : 32'h0,
                 (live_q.size() > 0) ? mem_data(live_q[0]) : 32'h0);
      if (e_mrv) chk($sformatf("rnd%0d.mem_req_a", cyc), ifc.mem_req_data.a, pcd);
      resp_fire = f[2] && e_rr;
      if (f[0]) begin
        if (resp_fire) model_dropped++;
        drop = drop + live_q.size() - (resp_fire ? 1 : 0);
        live_q.delete();
      end else if (drop > 0) begin
        if (resp_fire) begin
          drop--;
          model_dropped++;
        end
      end else if (e_fv && f[1]) begin
        $display("rnd fetched pc=%h raw=%h", live_q[0], rd);
        void'(live_q.pop_front());
      end
      if (resp_fire) void'(mem_q.pop_front());
      if (e_mrv && f[3]) begin
        live_q.push_back(pcd);
        mem_q.push_back(pcd);
        model_issued++;
      end
      step();
    end
`ifdef IFETCH_PERF_EN
    chk("perf_issued_total", perf_issued, 32'(model_issued));
    chk("perf_dropped_total", perf_dropped, 32'(model_dropped));
`endif
    $display("random phase issued=%0d dropped=%0d", model_issued, model_dropped);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
